// File: rtl/siso_pkg.sv
// Shared types for the SISO decoder front end: default LLR width, LLR type and LIFO state encoding.
package siso_pkg;

    localparam int LLR_W_DEFAULT = 16;

    typedef logic [LLR_W_DEFAULT-1:0] llr_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } lifo_state_t;

endpackage

// File: rtl/lifo_ram.sv
// Simple dual-port storage for sys/parity pairs: one synchronous write port, one asynchronous read port.
module lifo_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sys_par_lifo.sv
// Frame-reversing LIFO for sys/parity LLR pairs; fills a frame, then drains it in reverse order.
// Optional sticky overflow flag enabled by defining SYS_PAR_LIFO_OVF_EN.
module sys_par_lifo
    import siso_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int LLR_W = LLR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LLR_W-1:0] sys,
    input  logic [LLR_W-1:0] parity,
    input  logic             valid_in,
    input  logic             last_in,
    output logic             ready_in,
    output logic [LLR_W-1:0] sys_out,
    output logic [LLR_W-1:0] par_out,
    output logic             valid_out,
    output logic             last_out,
    input  logic             out_ready
`ifdef SYS_PAR_LIFO_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);

    lifo_state_t        state;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      rd_next;
    logic [2*LLR_W-1:0] rd_data;
    logic               accept;
    logic               frame_end;
    logic               out_xfer;

    assign ready_in  = (state == FILL);
    assign accept    = (state == FILL) && valid_in;
    assign frame_end = last_in || (wr_ptr == LAST_IDX);
    assign out_xfer  = valid_out && out_ready;
    assign rd_next   = rd_ptr - PTR_ONE;

    lifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (2 * LLR_W),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata ({sys, parity}),
        .raddr (rd_next),
        .rdata (rd_data)
    );

    // Fill/drain control with registered output pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FILL;
            wr_ptr    <= PTR_ZERO;
            rd_ptr    <= PTR_ZERO;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            sys_out   <= {LLR_W{1'b0}};
            par_out   <= {LLR_W{1'b0}};
`ifdef SYS_PAR_LIFO_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        // The final pair is not in the RAM yet, so it is presented straight from the input.
                        if (frame_end) begin
                            state     <= DRAIN;
                            rd_ptr    <= wr_ptr;
                            valid_out <= 1'b1;
                            last_out  <= (wr_ptr == PTR_ZERO);
                            sys_out   <= sys;
                            par_out   <= parity;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                        end
`ifdef SYS_PAR_LIFO_OVF_EN
                        if ((wr_ptr == LAST_IDX) && !last_in) begin
                            ovf <= 1'b1;
                        end
`endif
                    end
                end
                DRAIN: begin
                    if (out_xfer) begin
                        if (rd_ptr == PTR_ZERO) begin
                            state     <= FILL;
                            wr_ptr    <= PTR_ZERO;
                            valid_out <= 1'b0;
                            last_out  <= 1'b0;
                        end else begin
                            rd_ptr             <= rd_next;
                            {sys_out, par_out} <= rd_data;
                            last_out           <= (rd_next == PTR_ZERO);
                        end
                    end
                end
                default: begin
                    state     <= FILL;
                    wr_ptr    <= PTR_ZERO;
                    valid_out <= 1'b0;
                    last_out  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_par_lifo.sv
// Directed scoreboard bench for sys_par_lifo; covers the ovf port when SYS_PAR_LIFO_OVF_EN is defined.
module tb_sys_par_lifo;

    localparam int DEPTH = 64;
    localparam int W     = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sys;
    logic [W-1:0] parity;
    logic         valid_in;
    logic         last_in;
    logic         ready_in;
    logic [W-1:0] sys_out;
    logic [W-1:0] par_out;
    logic         valid_out;
    logic         last_out;
    logic         out_ready;
`ifdef SYS_PAR_LIFO_OVF_EN
    logic         ovf;
    logic         m_ovf;
`endif

    typedef struct packed {
        logic [W-1:0] s;
        logic [W-1:0] p;
        logic         l;
    } ent_t;

    ent_t exp_q[$];
    ent_t frame[DEPTH];
    int   tests = 0;
    int   fails = 0;
    logic m_fill;
    int   m_cnt;

    always #5 clk = ~clk;

    sys_par_lifo #(.DEPTH(DEPTH), .LLR_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sys       (sys),
        .parity    (parity),
        .valid_in  (valid_in),
        .last_in   (last_in),
        .ready_in  (ready_in),
        .sys_out   (sys_out),
        .par_out   (par_out),
        .valid_out (valid_out),
        .last_out  (last_out),
        .out_ready (out_ready)
`ifdef SYS_PAR_LIFO_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive at negedge, check the state left by earlier edges, advance the model.
    task automatic cycle(input logic v, input logic [W-1:0] s, input logic [W-1:0] p,
                         input logic l, input logic o);
        ent_t e;
        @(negedge clk);
        rst = 1'b1; valid_in = v; sys = s; parity = p; last_in = l; out_ready = o;
        #1;
        check("ready_in", {15'd0, ready_in}, {15'd0, m_fill});
        check("valid_out", {15'd0, valid_out}, {15'd0, !m_fill});
`ifdef SYS_PAR_LIFO_OVF_EN
        check("ovf", {15'd0, ovf}, {15'd0, m_ovf});
`endif
        if (!m_fill) begin
            if (exp_q.size() > 0) begin
                check("sys_out", sys_out, exp_q[0].s);
                check("par_out", par_out, exp_q[0].p);
                check("last_out", {15'd0, last_out}, {15'd0, exp_q[0].l});
                if (o) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        m_fill = 1'b1;
                        m_cnt  = 0;
                    end
                end
            end
        end else if (v) begin
            frame[m_cnt] = '{s: s, p: p, l: 1'b0};
`ifdef SYS_PAR_LIFO_OVF_EN
            if (!l && m_cnt == DEPTH - 1) m_ovf = 1'b1;
`endif
            if (l || m_cnt == DEPTH - 1) begin
                for (int i = m_cnt; i >= 0; i--) begin
                    e   = frame[i];
                    e.l = (i == 0);
                    exp_q.push_back(e);
                end
                m_fill = 1'b0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; valid_in = 1'b0; last_in = 1'b0; out_ready = 1'b0;
        sys = 16'd0; parity = 16'd0;
        #1;
        check("rst_valid_out", {15'd0, valid_out}, 16'd0);
        check("rst_last_out", {15'd0, last_out}, 16'd0);
        check("rst_sys_out", sys_out, 16'd0);
        check("rst_par_out", par_out, 16'd0);
        check("rst_ready_in", {15'd0, ready_in}, 16'd1);
`ifdef SYS_PAR_LIFO_OVF_EN
        check("rst_ovf", {15'd0, ovf}, 16'd0);
        m_ovf = 1'b0;
`endif
        exp_q.delete();
        m_fill = 1'b1;
        m_cnt  = 0;
    endtask

    initial begin
        rst = 1'b0; valid_in = 1'b0; last_in = 1'b0; out_ready = 1'b0;
        sys = 16'd0; parity = 16'd0;
        m_fill = 1'b1; m_cnt = 0;
`ifdef SYS_PAR_LIFO_OVF_EN
        m_ovf = 1'b0;
`endif
        do_reset();

        // Four-pair frame, downstream always ready.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 16'(i), 16'(i + 10), i == 4, 1'b1);
        repeat (6) cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);

        // Same frame with out_ready pattern 1,0,0 repeating.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 16'(i), 16'(i + 10), i == 4, 1'b1);
        for (int k = 0; k < 14; k++) cycle(1'b0, 16'd0, 16'd0, 1'b0, (k % 3) == 0);

        // Single-pair frame.
        cycle(1'b1, 16'd7, 16'd9, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);

        // 70 pairs without last_in: the 64th forces drain, the rest are dropped.
        for (int i = 0; i < 70; i++) cycle(1'b1, 16'(i + 1), 16'(i + 1001), 1'b0, 1'b1);
        repeat (64) cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);

        // Input held valid while draining must not disturb the stored frame.
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'(i + 21), 16'(i + 121), i == 2, 1'b1);
        repeat (4) cycle(1'b1, 16'hdead, 16'hbeef, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 16'hdead, 16'hbeef, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);

        // Reset mid-drain, then a fresh two-pair frame.
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'(i + 31), 16'(i + 131), i == 2, 1'b1);
        repeat (2) cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        do_reset();
        cycle(1'b1, 16'd41, 16'd141, 1'b0, 1'b1);
        cycle(1'b1, 16'd42, 16'd142, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);

        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sys_par_lifo.md
SYS_PAR_LIFO -- requirements
Module: sys_par_lifo

Interface
REQ-001 Parameter DEPTH, default 64, maximum number of sys/parity pairs per frame (power of two, >= 4).
REQ-002 Parameter LLR_W, default 16, LLR width in bits.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 sys  input  LLR_W  systematic LLR from the upstream splitter.
REQ-006 parity  input  LLR_W  parity LLR paired with sys.
REQ-007 valid_in  input  1  sys/parity pair valid this cycle.
REQ-008 last_in  input  1  qualifies the final pair of a frame; meaningful only with valid_in.
REQ-009 ready_in  output  1  high when a pair is accepted; a pair transfers only on valid_in & ready_in.
REQ-010 sys_out  output  LLR_W  systematic LLR, frame order reversed.
REQ-011 par_out  output  LLR_W  parity LLR, frame order reversed.
REQ-012 valid_out  output  1  output pair valid.
REQ-013 last_out  output  1  marks the output pair that was written first (frame index 0).
REQ-014 out_ready  input  1  downstream accepts; an output transfers on valid_out & out_ready.
REQ-015 ovf  output  1  sticky overflow flag; present only with SYS_PAR_LIFO_OVF_EN.

Function
REQ-016 The block SHALL use FSM states FILL and DRAIN only.
REQ-017 In FILL, ready_in SHALL be 1, and each accepted pair SHALL be written at wr_ptr, after which wr_ptr increments.
REQ-018 FILL SHALL go to DRAIN on the cycle a pair with last_in=1 is accepted, or when the accepted pair fills entry DEPTH-1.
REQ-019 In DRAIN, ready_in SHALL be 0, and pairs presented on the input SHALL be ignored and not stored.
REQ-020 On entry to DRAIN, rd_ptr SHALL equal the index of the last written pair; valid_out SHALL rise on the first cycle in DRAIN, one cycle after the final write is accepted.
REQ-021 sys_out/par_out SHALL be registered and SHALL hold stable while valid_out=1 and out_ready=0.
REQ-022 On each output transfer, rd_ptr SHALL decrement and the next pair SHALL be presented on the following cycle with no bubble.
REQ-023 last_out SHALL be 1 only while rd_ptr=0 and valid_out=1.
REQ-024 The transfer with last_out=1 SHALL return the FSM to FILL with wr_ptr=0; valid_out SHALL be 0 on the next cycle, and ready_in SHALL be 1 on that same cycle.
REQ-025 A single-pair frame (last_in on the first pair) SHALL drain one pair with last_out=1.
REQ-026 Pointers SHALL be clog2(DEPTH) bits wide and SHALL never wrap; frame length is implied by wr_ptr.
REQ-027 Data SHALL pass through unmodified, with no arithmetic on the LLR values.

Reset
REQ-028 While rst=0, the FSM SHALL be FILL, wr_ptr=0, rd_ptr=0, valid_out=0, last_out=0, sys_out=0, par_out=0, and ovf=0.
REQ-029 Reset asserted mid-frame or mid-drain SHALL discard the frame.
REQ-030 Storage array contents SHALL NOT be reset.
REQ-031 After release, the first rising edge SHALL accept a pair.

Configuration
REQ-032 Macro SYS_PAR_LIFO_OVF_EN defined: ovf SHALL set when the pair written at DEPTH-1 has last_in=0, and SHALL hold until reset.
REQ-033 Macro undefined: the ovf port and its logic SHALL be absent, and the forced-DRAIN behaviour of REQ-018 SHALL be unchanged.

Structure
REQ-034 Package siso_pkg SHALL hold LLR_W default, typedef llr_t, and enum lifo_state_t {FILL, DRAIN}.
REQ-035 Storage SHALL be sub-module lifo_ram:
- simple dual-port, one write port, one asynchronous read port;
- entries are 2*LLR_W wide, DEPTH deep.

Verification
REQ-036 Frame of 4 pairs (sys=1..4, par=11..14), out_ready=1:
- outputs (4,14),(3,13),(2,12),(1,11);
- last_out only on (1,11);
- first valid_out one cycle after the write of pair 4.
REQ-037 Same frame with out_ready toggled 1,0,0,1,...: each pair is held stable while stalled, no pair is lost or duplicated, and order is preserved.
REQ-038 Single pair (sys=7, par=9, last_in=1): one output (7,9) with last_out=1, then ready_in=1 on the next cycle.
REQ-039 DEPTH=64 with 70 pairs and no last_in:
- the 64th pair forces DRAIN and pairs 65-70 are dropped;
- 64 outputs are produced in reverse order;
- ovf=1 with the macro defined; the ovf port is absent without it.
REQ-040 rst=0 pulsed after 2 of 3 outputs drained: valid_out=0 immediately, ovf=0, state FILL, and a new 2-pair frame drains correctly.
REQ-041 Input valid_in held high during DRAIN: ready_in=0 and no corruption of the stored frame.
